// File: rtl/fft_pkg.sv
// Shared FFT pipeline definitions: default frame size, bit-reversal helper,
// and the reorder stage's read FSM state type.
package fft_pkg;

   localparam int FFT_LOG_N_DEFAULT = 6;
   localparam int FFT_LOG_N_MAX     = 12;

   typedef enum logic {
      IDLE = 1'b0,
      READ = 1'b1
   } rd_state_t;

   // Reverses the low 'bits' bits of value; bits above that come back as 0.
   function automatic logic [FFT_LOG_N_MAX-1:0] bitrev(
      input logic [FFT_LOG_N_MAX-1:0] value,
      input int                       bits
   );
      logic [FFT_LOG_N_MAX-1:0] w_res;
      w_res = '0;
      for (int b = 0; b < FFT_LOG_N_MAX; b++) begin
         if (b < bits) begin
            w_res[b] = value[bits-1-b];
         end
      end
      return w_res;
   endfunction

endpackage

// File: rtl/bitrev_reorder_ram.sv
// Simple dual-port frame buffer for bitrev_reorder: one write port and one
// registered read port, address = {bank, index}.
module reorder_ram #(
   parameter int DW = 32,
   parameter int AW = 7
) (
   input  logic          clock,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [DW-1:0] i_wdata,
   input  logic [AW-1:0] i_raddr,
   output logic [DW-1:0] o_rdata
);

   logic [DW-1:0] r_mem [2**AW];

   // NOTE: the array has no reset so it maps onto block RAM; the reader never
   // consumes an entry the writer has not filled since the last reset.
   always_ff @(posedge clock) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
      o_rdata <= r_mem[i_raddr];
   end

endmodule

// File: rtl/bitrev_reorder.sv
// Bit-reversed to natural order reorder stage after the last SDF FFT stage.
// Optional macro BITREV_REORDER_XMASK_EN drives outputs to x while odata_en is 0.
module bitrev_reorder
   import fft_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int LOG_N = FFT_LOG_N_DEFAULT
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             idata_en,
   input  logic [WIDTH-1:0] idata_r,
   input  logic [WIDTH-1:0] idata_i,
   output logic             odata_en,
   output logic [WIDTH-1:0] odata_r,
   output logic [WIDTH-1:0] odata_i
);

   localparam int             N    = 1 << LOG_N;
   localparam logic [LOG_N-1:0] LAST = LOG_N'(N - 1);
   localparam logic [LOG_N-1:0] ONE  = LOG_N'(1);

   logic [LOG_N-1:0]   r_wcnt;
   logic               r_wbank;
   logic [1:0]         r_ready;
   rd_state_t          r_state;
   logic               r_rbank;
   logic [LOG_N-1:0]   r_rcnt;
   logic               r_ren_d1;

   logic               w_wrap;
   logic               w_last_rd;
   logic [1:0]         w_set;
   logic [1:0]         w_clr;
   logic [LOG_N-1:0]   w_widx;
   logic [LOG_N:0]     w_waddr;
   logic [LOG_N:0]     w_raddr;
   logic [2*WIDTH-1:0] w_rdata;

   assign w_widx    = LOG_N'(bitrev(FFT_LOG_N_MAX'(r_wcnt), LOG_N));
   assign w_waddr   = {r_wbank, w_widx};
   assign w_raddr   = {r_rbank, r_rcnt};
   assign w_wrap    = idata_en && (r_wcnt == LAST);
   assign w_last_rd = (r_state == READ) && (r_rcnt == LAST);
   assign w_set     = w_wrap    ? (2'b01 << r_wbank) : 2'b00;
   assign w_clr     = w_last_rd ? (2'b01 << r_rbank) : 2'b00;

   reorder_ram #(
      .DW (2*WIDTH),
      .AW (LOG_N+1)
   ) u_ram (
      .clock   (clock),
      .i_we    (idata_en),
      .i_waddr (w_waddr),
      .i_wdata ({idata_r, idata_i}),
      .i_raddr (w_raddr),
      .o_rdata (w_rdata)
   );

   // NOTE: sequential state uses non-blocking assignments only, so every
   // block sees the pre-edge values of r_ready, r_rbank and r_wcnt.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_wcnt  <= '0;
         r_wbank <= 1'b0;
      end else if (idata_en) begin
         r_wcnt <= r_wcnt + ONE;
         if (w_wrap) begin
            r_wbank <= ~r_wbank;
         end
      end
   end

   // Set and clear always target different banks, so the order is irrelevant.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_ready <= 2'b00;
      end else begin
         r_ready <= (r_ready & ~w_clr) | w_set;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_rbank <= 1'b0;
         r_rcnt  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (|r_ready) begin
                  r_state <= READ;
                  r_rbank <= ~r_ready[0];
                  r_rcnt  <= '0;
               end
            end
            READ: begin
               r_rcnt <= r_rcnt + ONE;
               // Chain straight into the other bank to keep the stream gapless.
               if (r_rcnt == LAST) begin
                  if (r_ready[~r_rbank] || w_set[~r_rbank]) begin
                     r_rbank <= ~r_rbank;
                  end else begin
                     r_state <= IDLE;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_ren_d1 <= 1'b0;
         odata_en <= 1'b0;
         odata_r  <= '0;
         odata_i  <= '0;
      end else begin
         r_ren_d1 <= (r_state == READ);
         odata_en <= r_ren_d1;
         if (r_ren_d1) begin
            odata_r <= w_rdata[2*WIDTH-1:WIDTH];
            odata_i <= w_rdata[WIDTH-1:0];
         end
`ifdef BITREV_REORDER_XMASK_EN
         else begin
            odata_r <= 'x;
            odata_i <= 'x;
         end
`else
`endif
      end
   end

endmodule

// File: tb/tb_bitrev_reorder.sv
// Self-checking bench for bitrev_reorder: table-driven frame, random frames
// against a natural-order scoreboard, gaps, mid-frame reset and LOG_N=1.
module tb_bitrev_reorder;

   localparam int W = 16;

   typedef struct {
      logic [W-1:0] in_r;
      logic [W-1:0] in_i;
      logic [W-1:0] exp_r;
      logic [W-1:0] exp_i;
   } vec_t;

   typedef struct {
      int           due;
      logic [W-1:0] r;
      logic [W-1:0] i;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         en_a, oen_a, en_b, oen_b;
   logic [W-1:0] r_a, i_a, or_a, oi_a;
   logic [W-1:0] r_b, i_b, or_b, oi_b;

   int           cyc = 0;
   int           errors = 0;
   int           checks = 0;
   bit           mon_en = 1'b0;
   exp_t         q[$];
   logic [W-1:0] last_r, last_i;
   vec_t         tbl[8];
   int           tb_e_b;
   int           waited;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   bitrev_reorder #(.WIDTH(W), .LOG_N(3)) dut_a (
      .clock(clk), .reset_n(rst_n), .idata_en(en_a), .idata_r(r_a), .idata_i(i_a),
      .odata_en(oen_a), .odata_r(or_a), .odata_i(oi_a));

   bitrev_reorder #(.WIDTH(W), .LOG_N(1)) dut_b (
      .clock(clk), .reset_n(rst_n), .idata_en(en_b), .idata_r(r_b), .idata_i(i_b),
      .odata_en(oen_b), .odata_r(or_b), .odata_i(oi_b));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int rev(input int v, input int bits);
      int res = 0;
      for (int b = 0; b < bits; b++) res = res * 2 + ((v >> b) % 2);
      return res;
   endfunction

   // Drives one 8-sample frame in arrival order; schedules the expected
   // natural-order output starting three edges after the last capture.
   task automatic drive_a(input logic [W-1:0] rv[8], input logic [W-1:0] iv[8],
                          input logic [W-1:0] er[8], input logic [W-1:0] ei[8],
                          input bit gapped);
      int t;
      for (int p = 0; p < 8; p++) begin
         if (gapped) begin
            repeat ($urandom_range(0, 2)) begin
               @(negedge clk);
               en_a = 1'b0;
            end
         end
         @(negedge clk);
         en_a = 1'b1;
         r_a  = rv[p];
         i_a  = iv[p];
         if (p == 7) begin
            t = cyc + 1;
            for (int k = 0; k < 8; k++) q.push_back('{due: t + 3 + k, r: er[k], i: ei[k]});
         end
      end
   endtask

   task automatic rand_frame(input bit gapped);
      logic [W-1:0] nr[8], ni[8], rv[8], iv[8];
      for (int k = 0; k < 8; k++) begin
         nr[k] = W'($urandom);
         ni[k] = W'($urandom);
      end
      for (int p = 0; p < 8; p++) begin
         rv[p] = nr[rev(p, 3)];
         iv[p] = ni[rev(p, 3)];
      end
      drive_a(rv, iv, nr, ni, gapped);
   endtask

   task automatic table_frame(input bit gapped);
      logic [W-1:0] rv[8], iv[8], er[8], ei[8];
      for (int k = 0; k < 8; k++) begin
         rv[k] = tbl[k].in_r;
         iv[k] = tbl[k].in_i;
         er[k] = tbl[k].exp_r;
         ei[k] = tbl[k].exp_i;
      end
      drive_a(rv, iv, er, ei, gapped);
   endtask

   task automatic idle_a(input int n);
      repeat (n) begin
         @(negedge clk);
         en_a = 1'b0;
      end
   endtask

   // Every cycle: either the scheduled sample is due, or the output is idle.
   always @(negedge clk) begin
      if (mon_en) begin
         exp_t e;
         logic [W-1:0] xv;
         xv = 'x;
         if (q.size() > 0 && q[0].due < cyc) begin
            check("missed_sample", 32'(cyc), 32'(q[0].due));
            void'(q.pop_front());
         end
         if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            check("a_en", 32'(oen_a), 32'd1);
            check("a_data_r", 32'(or_a), 32'(e.r));
            check("a_data_i", 32'(oi_a), 32'(e.i));
            last_r = e.r;
            last_i = e.i;
         end else begin
            check("a_en_idle", 32'(oen_a), 32'd0);
`ifdef BITREV_REORDER_XMASK_EN
            check("a_xmask_r", 32'(or_a), 32'(xv));
            check("a_xmask_i", 32'(oi_a), 32'(xv));
`else
            check("a_hold_r", 32'(or_a), 32'(last_r));
            check("a_hold_i", 32'(oi_a), 32'(last_i));
`endif
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int order[8];
      order = '{0, 4, 2, 6, 1, 5, 3, 7};
      for (int k = 0; k < 8; k++) begin
         tbl[k].in_r  = W'(order[k]);
         tbl[k].in_i  = W'(10 * order[k]);
         tbl[k].exp_r = W'(k);
         tbl[k].exp_i = W'(10 * k);
      end

      rst_n = 1'b0;
      en_a = 1'b0; r_a = '0; i_a = '0;
      en_b = 1'b0; r_b = '0; i_b = '0;
      last_r = '0; last_i = '0;
      repeat (3) @(negedge clk);
      check("rst_a_en", 32'(oen_a), 32'd0);
      check("rst_a_r",  32'(or_a),  32'd0);
      check("rst_a_i",  32'(oi_a),  32'd0);
      check("rst_b_en", 32'(oen_b), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      mon_en = 1'b1;

      // Table frame, contiguous, then an idle gap.
      table_frame(1'b0);
      idle_a(14);
      // Four back-to-back random frames with continuous enable.
      for (int f = 0; f < 4; f++) rand_frame(1'b0);
      idle_a(14);
      // Same table frame with random gaps, then gapped random frames.
      table_frame(1'b1);
      idle_a(14);
      rand_frame(1'b1);
      rand_frame(1'b1);
      idle_a(14);
      check("drain_a", 32'(q.size()), 32'd0);

      // Reset after 5 samples of frame 2 while frame 1 is being output.
      table_frame(1'b0);
      for (int p = 0; p < 5; p++) begin
         @(negedge clk);
         en_a = 1'b1;
         r_a  = W'($urandom);
         i_a  = W'($urandom);
      end
      @(posedge clk);
      #2;
      check("pre_rst_en", 32'(oen_a), 32'd1);
      mon_en = 1'b0;
      rst_n  = 1'b0;
      #1;
      check("async_rst_en", 32'(oen_a), 32'd0);
      check("async_rst_r",  32'(or_a),  32'd0);
      check("async_rst_i",  32'(oi_a),  32'd0);
      q.delete();
      en_a = 1'b0;
      repeat (2) @(negedge clk);
      rst_n  = 1'b1;
      last_r = '0;
      last_i = '0;
      @(negedge clk);
      mon_en = 1'b1;
      rand_frame(1'b0);
      idle_a(14);
      check("drain_rst", 32'(q.size()), 32'd0);
      mon_en = 1'b0;

      // LOG_N=1: alternating two-sample frames stream out gaplessly.
      waited = 0;
      fork
         begin
            for (int f = 0; f < 4; f++) begin
               for (int s = 0; s < 2; s++) begin
                  @(negedge clk);
                  en_b = 1'b1;
                  r_b  = W'(s + 1);
                  i_b  = W'(10 * (s + 1));
                  if (f == 0 && s == 1) tb_e_b = cyc + 1;
               end
            end
            @(negedge clk);
            en_b = 1'b0;
         end
         begin
            @(negedge clk);
            while (!oen_b && waited < 30) begin
               @(negedge clk);
               waited++;
            end
            check("b_first_cycle", 32'(cyc), 32'(tb_e_b + 3));
            for (int k = 0; k < 8; k++) begin
               check("b_en",     32'(oen_b), 32'd1);
               check("b_data_r", 32'(or_b),  32'((k % 2) + 1));
               check("b_data_i", 32'(oi_b),  32'(10 * ((k % 2) + 1)));
               @(negedge clk);
            end
            check("b_end_en", 32'(oen_b), 32'd0);
         end
      join

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
